// File: rtl/iob_fifo_pkg.sv
// Width helpers shared by the asymmetric FIFO and its memory.
package iob_fifo_pkg;

  // Larger of two widths or ratios.
  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Smaller of two widths or ratios.
  function automatic int unsigned min_w(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // log2 of a power-of-two width ratio (ceil for non-powers).
  function automatic int unsigned log2_ratio(input int unsigned r);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < r) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/iob_sync_asym_ram.sv
// Single-clock asymmetric two-port memory built from MIN_W-wide banks.
// Address space is in MIN_W words: word a lives in bank (a mod N_BANKS),
// row (a / N_BANKS). The wide side touches every bank in one access.
module iob_sync_asym_ram
  import iob_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_ptr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_ptr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int unsigned MIN_W   = min_w(W_DATA_W, R_DATA_W);
  localparam int unsigned W_RATIO = W_DATA_W / MIN_W;
  localparam int unsigned R_RATIO = R_DATA_W / MIN_W;
  localparam int unsigned N_BANKS = max_w(W_RATIO, R_RATIO);
  localparam int unsigned SEL_W   = log2_ratio(N_BANKS);
  localparam int unsigned ROW_W   = ADDR_W - SEL_W;
  localparam int unsigned ROW_WS  = (ROW_W > 0) ? ROW_W : 1;
  localparam int unsigned DEPTH   = 1 << ROW_W;
  localparam int unsigned MASK    = N_BANKS - 1;

  logic [ROW_WS-1:0]   w_row;
  logic [ROW_WS-1:0]   r_row;
  logic [MIN_W-1:0]    rd_word [N_BANKS];
  logic [R_DATA_W-1:0] r_next;

  assign w_row = ROW_WS'(w_ptr >> SEL_W);
  assign r_row = ROW_WS'(r_ptr >> SEL_W);

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    // Bank b belongs to the write lane group starting at LANE_BASE; on the
    // wide-write side that base is 0 and the pointer lane bits are 0 too.
    localparam int unsigned LANE_BASE = b - (b % W_RATIO);
    localparam int unsigned LANE_OFF  = b % W_RATIO;

    logic [MIN_W-1:0] mem [DEPTH];
    logic             we;
    logic [MIN_W-1:0] wd;

    assign we = w_en && ((w_ptr & ADDR_W'(MASK)) == ADDR_W'(LANE_BASE));
    assign wd = w_data[LANE_OFF*MIN_W +: MIN_W];

    // Bank storage; not reset, stale contents become unreachable.
    always_ff @(posedge clk) begin
      if (we) mem[w_row] <= wd;
    end

    assign rd_word[b] = mem[r_row];
  end

  if (N_BANKS == 1) begin : g_rd_one
    assign r_next = rd_word[0];
  end else begin : g_rd_sel
    // Read slice j comes from pointer + j; narrow reads use only slice 0.
    always_comb begin
      r_next = '0;
      for (int unsigned j = 0; j < R_RATIO; j++) begin
        r_next[j*MIN_W +: MIN_W] =
          rd_word[SEL_W'((r_ptr + ADDR_W'(j)) & ADDR_W'(MASK))];
      end
    end
  end

  // Registered read port; holds when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_data <= '0;
    else if (r_en) r_data <= r_next;
  end

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO with independent write and read widths.
// Pointers and level count MIN_W words; flags are registered from level.
module iob_sync_asym_fifo
  import iob_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
);

  localparam int unsigned MIN_W   = min_w(W_DATA_W, R_DATA_W);
  localparam int unsigned W_RATIO = W_DATA_W / MIN_W;
  localparam int unsigned R_RATIO = R_DATA_W / MIN_W;
  localparam int unsigned LVL_W   = ADDR_W + 1;
  localparam int unsigned CAP     = 1 << ADDR_W;

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic              wr_acc;
  logic              rd_acc;
  logic [LVL_W-1:0]  level_next;

  // Requests are qualified only by the current registered flags.
  assign wr_acc = w_en & ~w_full;
  assign rd_acc = r_en & ~r_empty;

  // Occupancy after this edge's accepted transfers.
  always_comb begin
    level_next = level;
    if (wr_acc) level_next = level_next + LVL_W'(W_RATIO);
    if (rd_acc) level_next = level_next - LVL_W'(R_RATIO);
  end

  // Pointers, level and flags; flags follow level_next on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level   <= '0;
      w_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ADDR_W'(W_RATIO);
      if (rd_acc) r_ptr <= r_ptr + ADDR_W'(R_RATIO);
      level   <= level_next;
      w_full  <= level_next > LVL_W'(CAP - W_RATIO);
      r_empty <= level_next < LVL_W'(R_RATIO);
    end
  end

  iob_sync_asym_ram #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .w_en   (wr_acc),
    .w_ptr  (w_ptr),
    .w_data (w_data),
    .r_en   (rd_acc),
    .r_ptr  (r_ptr),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// Self-checking bench: 32->8, 8->32 and 8->8 instances of the FIFO.
module tb_iob_sync_asym_fifo;

  logic clk;
  logic rst;

  // 32 -> 8, ADDR_W = 4
  logic        a_w_en, a_r_en, a_w_full, a_r_empty;
  logic [31:0] a_w_data;
  logic [7:0]  a_r_data;
  logic [4:0]  a_level;
  // 8 -> 32, ADDR_W = 4
  logic        b_w_en, b_r_en, b_w_full, b_r_empty;
  logic [7:0]  b_w_data;
  logic [31:0] b_r_data;
  logic [4:0]  b_level;
  // 8 -> 8, ADDR_W = 3
  logic        c_w_en, c_r_en, c_w_full, c_r_empty;
  logic [7:0]  c_w_data;
  logic [7:0]  c_r_data;
  logic [3:0]  c_level;

  int n_tests;
  int n_fail;

  iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_a (
    .clk(clk), .rst(rst), .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
    .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty), .level(a_level));

  iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_b (
    .clk(clk), .rst(rst), .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
    .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty), .level(b_level));

  iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(8), .ADDR_W(3)) u_c (
    .clk(clk), .rst(rst), .w_en(c_w_en), .w_data(c_w_data), .w_full(c_w_full),
    .r_en(c_r_en), .r_data(c_r_data), .r_empty(c_r_empty), .level(c_level));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w_en;
    logic        r_en;
    logic [31:0] w_data;
    int          lvl;
    logic        full;
    logic        empty;
    logic [7:0]  rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] d,
                              input int l, input logic f, input logic e,
                              input logic [7:0] rd);
    vec_t v;
    v.w_en = we; v.r_en = re; v.w_data = d;
    v.lvl = l; v.full = f; v.empty = e; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string nm, input int l, input logic f, input logic e,
                       input logic [7:0] rd);
    chk({nm, "_level"}, 32'(a_level), 32'(l));
    chk({nm, "_full"},  32'(a_w_full), 32'(f));
    chk({nm, "_empty"}, 32'(a_r_empty), 32'(e));
    chk({nm, "_rdata"}, 32'(a_r_data), 32'(rd));
  endtask

  // One cycle on instance A: drive, let the edge take it, sample just after.
  task automatic a_cycle(input logic we, input logic re, input logic [31:0] d);
    a_w_en = we; a_r_en = re; a_w_data = d;
    @(posedge clk); #1;
    a_w_en = 1'b0; a_r_en = 1'b0;
  endtask

  task automatic b_cycle(input logic we, input logic re, input logic [7:0] d);
    b_w_en = we; b_r_en = re; b_w_data = d;
    @(posedge clk); #1;
    b_w_en = 1'b0; b_r_en = 1'b0;
  endtask

  task automatic chk_b(input string nm, input int l, input logic e, input logic [31:0] rd);
    chk({nm, "_level"}, 32'(b_level), 32'(l));
    chk({nm, "_empty"}, 32'(b_r_empty), 32'(e));
    chk({nm, "_rdata"}, b_r_data, rd);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_rd;
    logic       we, re, wacc, racc;
    logic [7:0] d;
    int         sent, got, wp, rp;

    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    a_w_en = 0; a_r_en = 0; a_w_data = '0;
    b_w_en = 0; b_r_en = 0; b_w_data = '0;
    c_w_en = 0; c_r_en = 0; c_w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("rst_a", 0, 0, 1, 8'h00);
    chk_b("rst_b", 0, 1, 32'h0);
    chk("rst_b_full", 32'(b_w_full), 32'd0);
    chk("rst_c_level", 32'(c_level), 32'd0);
    chk("rst_c_empty", 32'(c_r_empty), 32'd1);
    rst = 1'b0;

    // Table for 32->8: unpack order, fill/full, rejected ops, simultaneous.
    vq.push_back(mk(1, 0, 32'hDDCCBBAA, 4, 0, 0, 8'h00));
    vq.push_back(mk(0, 1, 32'h0, 3, 0, 0, 8'hAA));
    vq.push_back(mk(0, 1, 32'h0, 2, 0, 0, 8'hBB));
    vq.push_back(mk(0, 1, 32'h0, 1, 0, 0, 8'hCC));
    vq.push_back(mk(0, 1, 32'h0, 0, 0, 1, 8'hDD));
    vq.push_back(mk(0, 1, 32'h0, 0, 0, 1, 8'hDD));
    vq.push_back(mk(1, 0, 32'h03020100, 4, 0, 0, 8'hDD));
    vq.push_back(mk(1, 0, 32'h07060504, 8, 0, 0, 8'hDD));
    vq.push_back(mk(1, 0, 32'h0B0A0908, 12, 0, 0, 8'hDD));
    vq.push_back(mk(1, 0, 32'h0F0E0D0C, 16, 1, 0, 8'hDD));
    vq.push_back(mk(1, 0, 32'h12345678, 16, 1, 0, 8'hDD));
    vq.push_back(mk(0, 1, 32'h0, 15, 1, 0, 8'h00));
    vq.push_back(mk(0, 1, 32'h0, 14, 1, 0, 8'h01));
    vq.push_back(mk(0, 1, 32'h0, 13, 1, 0, 8'h02));
    vq.push_back(mk(0, 1, 32'h0, 12, 0, 0, 8'h03));
    vq.push_back(mk(1, 1, 32'h13121110, 15, 1, 0, 8'h04));
    for (int k = 0; k < 11; k++)
      vq.push_back(mk(0, 1, 32'h0, 14 - k, (14 - k) > 12, 0, 8'(8'h05 + k)));
    vq.push_back(mk(1, 1, 32'h17161514, 7, 0, 0, 8'h10));
    for (int k = 0; k < 7; k++)
      vq.push_back(mk(0, 1, 32'h0, 6 - k, 0, k == 6, 8'(8'h11 + k)));

    for (int i = 0; i < vq.size(); i++) begin
      a_cycle(vq[i].w_en, vq[i].r_en, vq[i].w_data);
      chk_a($sformatf("vec%0d", i), vq[i].lvl, vq[i].full, vq[i].empty, vq[i].rd);
    end

    // 8->32: reads stay blocked until a whole word is buffered.
    b_cycle(1, 0, 8'h11); chk_b("b_w1", 1, 1, 32'h0);
    b_cycle(1, 0, 8'h22); chk_b("b_w2", 2, 1, 32'h0);
    b_cycle(1, 0, 8'h33); chk_b("b_w3", 3, 1, 32'h0);
    b_cycle(0, 1, 8'h00); chk_b("b_rrej", 3, 1, 32'h0);
    b_cycle(1, 0, 8'h44); chk_b("b_w4", 4, 0, 32'h0);
    b_cycle(0, 1, 8'h00); chk_b("b_rd", 0, 1, 32'h44332211);

    // 8->8 random stream against a queue model; depth 8, forces many wraps.
    sent = 0; got = 0; exp_rd = 8'h00;
    for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
      wp = ((cyc / 40) % 2 == 0) ? 85 : 25;
      rp = 110 - wp;
      we = (sent < 100) && ($urandom_range(0, 99) < wp);
      re = $urandom_range(0, 99) < rp;
      d  = 8'($urandom);
      c_w_en = we; c_r_en = re; c_w_data = d;
      wacc = we && (q.size() < 8);
      racc = re && (q.size() > 0);
      @(posedge clk); #1;
      if (racc) begin exp_rd = q.pop_front(); got++; end
      if (wacc) begin q.push_back(d); sent++; end
      chk("c_level", 32'(c_level), 32'(q.size()));
      chk("c_full",  32'(c_w_full), 32'(q.size() == 8));
      chk("c_empty", 32'(c_r_empty), 32'(q.size() == 0));
      chk("c_rdata", 32'(c_r_data), 32'(exp_rd));
    end
    c_w_en = 0; c_r_en = 0;
    chk("c_all_read", 32'(got), 32'd100);

    // Asynchronous reset at level 12, then fresh data reads back LSB first.
    a_cycle(1, 0, 32'hA3A2A1A0);
    a_cycle(1, 0, 32'hA7A6A5A4);
    a_cycle(1, 0, 32'hABAAA9A8);
    a_cycle(1, 0, 32'hAFAEADAC);
    for (int k = 0; k < 4; k++) a_cycle(0, 1, 32'h0);
    chk_a("pre_rst", 12, 0, 0, 8'hA3);
    #3 rst = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 1, 8'h00);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    a_cycle(1, 0, 32'hCAFEF00D); chk_a("post_rst_w", 4, 0, 0, 8'h00);
    a_cycle(0, 1, 32'h0);        chk_a("post_rst_r", 3, 0, 0, 8'h0D);
    a_cycle(0, 1, 32'h0);        chk_a("post_rst_r2", 2, 0, 0, 8'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_sync_asym_fifo.md
Name: iob_sync_asym_fifo

Overview:
- Single-clock FIFO with independent write and read data widths. Either side may be the wider one; equal widths are also legal.
- Builds on the team's asymmetric two-port memory. Adds pointer management, occupancy tracking, full/empty flags and a registered read port.
- Used as a width converter between a wide datapath and a narrow one in either direction, for example between a 32-bit bus and a byte-wide peripheral stream.

Parameters:
- W_DATA_W, 32, write port width in bits.
- R_DATA_W, 8, read port width in bits.
- ADDR_W, 4, log2 of capacity counted in min-width words. Capacity = 2**ADDR_W x min(W_DATA_W, R_DATA_W) bits.
- Derived: MIN_W = min(W_DATA_W, R_DATA_W); W_RATIO = W_DATA_W/MIN_W; R_RATIO = R_DATA_W/MIN_W. At most one of W_RATIO and R_RATIO exceeds 1.
- Legal values: the width ratio is a power of two, and 2**ADDR_W >= max(W_RATIO, R_RATIO).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- w_en  input  1  write request.
- w_data  input  W_DATA_W  write data.
- w_full  output  1  a full write word cannot be accepted.
- r_en  input  1  read request.
- r_data  output  R_DATA_W  read data, registered.
- r_empty  output  1  a full read word is not available.
- level  output  ADDR_W+1  occupancy in MIN_W words, range 0..2**ADDR_W.

Behaviour:
- Reset (asynchronous, immediate):
  - write pointer and read pointer = 0; level = 0; r_data = 0; r_empty = 1; w_full = 0.
  - Storage contents are not cleared; they become unreachable.
- Flags:
  - Both flags are registered functions of level; there is no combinational path from w_en or r_en.
  - w_full = (level > 2**ADDR_W - W_RATIO).
  - r_empty = (level < R_RATIO).
- Accepting requests:
  - A write is accepted iff w_en && !w_full. A read is accepted iff r_en && !r_empty.
  - A rejected request is a silent no-op: pointers, level and r_data are unchanged, and no error flag is raised.
- Pointers and wrap-around:
  - Both pointers are ADDR_W bits and count MIN_W words.
  - An accepted write advances the write pointer by W_RATIO; an accepted read advances the read pointer by R_RATIO.
  - Pointers wrap modulo 2**ADDR_W naturally and stay aligned to their own ratio.
- Level update: level_next = level + W_RATIO·wr_acc − R_RATIO·rd_acc. Flags follow on the same edge.
- Simultaneous write and read in one cycle:
  - Both are evaluated against the current flags only.
  - At full, a read is accepted but a write is still rejected; at empty, a write is accepted but a read is still rejected.
- Slice ordering (little-endian):
  - Wide write: w_data[(i+1)·MIN_W−1 -: MIN_W] is stored at write pointer + i, for i = 0..W_RATIO−1. The LSB slice is read out first.
  - Wide read: r_data slice i comes from read pointer + i. The first-written narrow word lands in the LSBs.
- Read latency:
  - r_data updates on the edge that accepts the read and is valid from the following cycle.
  - r_data holds its value when no read is accepted.
- Write-to-read latency: data written on edge N is readable by a read accepted on edge N+1, since r_empty updates on edge N. No read-during-write hazard exists: the slots being read are never the slots being written.
- Reset in mid-operation discards all buffered data.

Decomposition:
- Shared package iob_fifo_pkg: the max and min width helpers and a ratio/log2-ratio helper function. No typedefs are needed.
- One natural sub-module, iob_sync_asym_ram. It is single-clock with one write and one read port and is organised as max(W_RATIO, R_RATIO) banks of MIN_W width.
  - Wide-write case: all banks are written at once at address ptr>>log2(W_RATIO).
  - Wide-read case: one bank is written, selected by the pointer LSBs.
  - Reads are symmetric to writes. The read register lives in the sub-module.
- The FIFO top contains the pointers, level counter and flags.

Test Plan:
- Config 32→8, ADDR_W=4. Write 0xDDCCBBAA, then 4 reads → r_data = 0xAA, 0xBB, 0xCC, 0xDD, each on the cycle after its r_en. Level goes 4, 3, 2, 1, 0; r_empty = 1 after the 4th read.
- Config 32→8, fill. 4 writes → level 16, w_full = 1. A 5th write of 0x12345678 is ignored and level stays 16. After 1 read: level 15, w_full stays 1 (15 > 12). After 4 reads: level 12, w_full = 0.
- Config 8→32. Write 0x11, 0x22, 0x33 → level 3, r_empty = 1, and r_en has no effect. Write 0x44 → r_empty = 0 on the next cycle. A read then gives r_data = 0x44332211.
- Config 32→8 at level 4. Assert w_en and r_en in the same cycle → level 7 next cycle, and r_data equals the oldest byte.
- Equal widths 8→8, ADDR_W=3. Stream 100 random bytes with random w_en/r_en, forcing pointer wrap more than 10 times → output order matches a scoreboard. No write is accepted while w_full is set, and no read while r_empty is set.
- Reset mid-operation at level 12. Pulse rst asynchronously, mid-cycle → level = 0, r_empty = 1, w_full = 0 and r_data = 0 immediately. A subsequent write of 0xCAFEF00D reads back 0x0D first.
